start_token_fifo_ctrl: RTL and testbench

Control and read side of the start-token FIFO placed between an upstream task's start output and the downstream PE's start input in the Linear_Layer dataflow. It owns the occupancy pointer and the write/read handshakes around a shift-register store, and presents the oldest token on `if_dout` with a registered not-empty flag. The store shifts on write and is read by address, so reads never move data.

---
 rtl/start_fifo_pkg.sv | 16 +
 rtl/start_token_fifo_ctrl_srl.sv | 34 +++
 rtl/start_token_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_start_token_fifo_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/start_fifo_pkg.sv
// Shared types and constants for the start-token FIFO.
// Covers the controller state encoding and the empty-pointer sentinel.
package start_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  // The pointer is one bit wider than the address, so "empty" is all-ones.
  function automatic logic [31:0] empty_ptr(input int addr_width);
    return (32'd1 << (addr_width + 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/start_token_fifo_ctrl_srl.sv
// Shift-register token store: shifts on write, read by address.
// It has no reset, so its contents are undefined until written.
module start_token_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  // When empty, the address can point past the last entry, so it is masked to zero.
  always_comb begin
    dout = '0;
    if (int'(addr) < DEPTH) begin
      dout = mem[addr];
    end
  end

endmodule

// File: rtl/start_token_fifo_ctrl.sv
// Start-token FIFO controller: occupancy pointer, handshakes and registered flags.
// Optional occupancy output is enabled by defining START_FIFO_OCCUPANCY_EN.
module start_token_fifo_ctrl
  import start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
`ifdef START_FIFO_OCCUPANCY_EN
  ,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_EMPTY = PTR_W'(empty_ptr(ADDR_WIDTH));
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_BELOW = PTR_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  fifo_state_t      state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             push, pop;

  assign push = if_write & if_write_ce & if_full_n;
  assign pop  = if_read & if_read_ce & if_empty_n;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = PARTIAL;
          ptr_d   = '0;
        end
      end
      PARTIAL: begin
        if (push && !pop) begin
          ptr_d = ptr_q + PTR_ONE;
          if (ptr_d == PTR_LAST) begin
            state_d = FULL;
          end
        end else if (pop && !push) begin
          ptr_d = ptr_q - PTR_ONE;
          if (ptr_d == PTR_EMPTY) begin
            state_d = EMPTY;
          end
        end
      end
      FULL: begin
        if (pop) begin
          state_d = PARTIAL;
          ptr_d   = PTR_BELOW;
        end
      end
      default: begin
        state_d = EMPTY;
        ptr_d   = PTR_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      ptr_q      <= PTR_EMPTY;
      if_empty_n <= 1'b0;
      if_full_n  <= 1'b1;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      if_empty_n <= (state_d != EMPTY);
      if_full_n  <= (state_d != FULL);
    end
  end

`ifdef START_FIFO_OCCUPANCY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_num_data_valid <= '0;
    end else if (state_d == EMPTY) begin
      if_num_data_valid <= '0;
    end else begin
      if_num_data_valid <= ptr_d + PTR_ONE;
    end
  end
`endif

  start_token_srl #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_store (
    .clk (clk),
    .we  (push),
    .addr(ptr_q[ADDR_WIDTH-1:0]),
    .din (if_din),
    .dout(if_dout)
  );

endmodule

// File: tb/tb_start_token_fifo_ctrl.sv
// Directed self-checking bench for start_token_fifo_ctrl (DEPTH=3, 1-bit tokens).
// Occupancy checks are compiled in when START_FIFO_OCCUPANCY_EN is defined.
module tb_start_token_fifo_ctrl;

  logic       clk;
  logic       reset;
  logic       if_write_ce, if_write, if_din;
  logic       if_read_ce, if_read;
  logic       if_full_n, if_empty_n, if_dout;
`ifdef START_FIFO_OCCUPANCY_EN
  logic [2:0] if_num_data_valid;
`endif

  int vectors = 0;
  int miscompares = 0;

  start_token_fifo_ctrl #(.DATA_WIDTH(1), .ADDR_WIDTH(2), .DEPTH(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .if_write_ce(if_write_ce),
    .if_write   (if_write),
    .if_din     (if_din),
    .if_full_n  (if_full_n),
    .if_read_ce (if_read_ce),
    .if_read    (if_read),
    .if_dout    (if_dout),
    .if_empty_n (if_empty_n)
`ifdef START_FIFO_OCCUPANCY_EN
    ,
    .if_num_data_valid(if_num_data_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of requests, then settle 1 time unit past the rising edge.
  task automatic apply_stimulus(input logic w, input logic d, input logic r,
                                input logic wce = 1'b1, input logic rce = 1'b1);
    if_write    = w;
    if_din      = d;
    if_read     = r;
    if_write_ce = wce;
    if_read_ce  = rce;
    @(posedge clk);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic full_n, input logic empty_n);
    check_output({tag, "_full_n"}, {7'd0, if_full_n}, {7'd0, full_n});
    check_output({tag, "_empty_n"}, {7'd0, if_empty_n}, {7'd0, empty_n});
  endtask

  task automatic check_occ(input string tag, input logic [2:0] occ);
`ifdef START_FIFO_OCCUPANCY_EN
    check_output({tag, "_occ"}, {5'd0, if_num_data_valid}, {5'd0, occ});
`else
    if (occ > 3'd3) $display("[TB] unexpected occupancy argument in %s", tag);
`endif
  endtask

  initial begin
    reset = 1'b1;
    if_write = 0; if_din = 0; if_read = 0; if_write_ce = 1; if_read_ce = 1;
    repeat (2) @(posedge clk);
    #1;
    check_flags("reset", 1'b1, 1'b0);
    check_occ("reset", 3'd0);
    reset = 1'b0;
    apply_stimulus(0, 0, 0);
    check_flags("idle", 1'b1, 1'b0);

    // Single token round trip
    apply_stimulus(1, 1, 0);
    check_flags("push1", 1'b1, 1'b1);
    check_output("push1_dout", {7'd0, if_dout}, 8'h1);
    apply_stimulus(0, 0, 1);
    check_flags("pop1", 1'b1, 1'b0);

    // Fill to DEPTH=3 with 1,0,1
    apply_stimulus(1, 1, 0);
    check_occ("fill_a", 3'd1);
    apply_stimulus(1, 0, 0);
    check_flags("fill_b", 1'b1, 1'b1);
    check_occ("fill_b", 3'd2);
    apply_stimulus(1, 1, 0);
    check_flags("fill_c", 1'b0, 1'b1);
    check_output("fill_c_dout", {7'd0, if_dout}, 8'h1);
    check_occ("fill_c", 3'd3);
    apply_stimulus(1, 0, 0);
    check_flags("push_full", 1'b0, 1'b1);
    check_output("push_full_dout", {7'd0, if_dout}, 8'h1);
    check_occ("push_full", 3'd3);
    apply_stimulus(0, 0, 1);
    check_flags("drain_a", 1'b1, 1'b1);
    check_output("drain_a_dout", {7'd0, if_dout}, 8'h0);
    check_occ("drain_a", 3'd2);
    apply_stimulus(0, 0, 1);
    check_output("drain_b_dout", {7'd0, if_dout}, 8'h1);
    check_flags("drain_b", 1'b1, 1'b1);
    apply_stimulus(0, 0, 1);
    check_flags("drain_c", 1'b1, 1'b0);
    check_occ("drain_c", 3'd0);

    // Two tokens held (1 then 0), then simultaneous push/pop with din 1,1,0,1
    apply_stimulus(1, 1, 0);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 1, 1);
    check_output("pp1_dout", {7'd0, if_dout}, 8'h0);
    check_flags("pp1", 1'b1, 1'b1);
    apply_stimulus(1, 1, 1);
    check_output("pp2_dout", {7'd0, if_dout}, 8'h1);
    apply_stimulus(1, 0, 1);
    check_output("pp3_dout", {7'd0, if_dout}, 8'h1);
    apply_stimulus(1, 1, 1);
    check_output("pp4_dout", {7'd0, if_dout}, 8'h0);
    check_flags("pp4", 1'b1, 1'b1);
    check_occ("pp4", 3'd2);
    apply_stimulus(0, 0, 1);
    check_output("pp_drain_dout", {7'd0, if_dout}, 8'h1);
    check_flags("pp_drain_a", 1'b1, 1'b1);
    apply_stimulus(0, 0, 1);
    check_flags("pp_drain_b", 1'b1, 1'b0);

    // Enables low freeze the FIFO
    apply_stimulus(1, 1, 0);
    apply_stimulus(0, 0, 1, 1'b1, 1'b0);
    apply_stimulus(0, 0, 1, 1'b1, 1'b0);
    check_flags("rce_low", 1'b1, 1'b1);
    check_output("rce_low_dout", {7'd0, if_dout}, 8'h1);
    apply_stimulus(1, 0, 0, 1'b0, 1'b1);
    check_output("wce_low_dout", {7'd0, if_dout}, 8'h1);
    check_occ("wce_low", 3'd1);
    apply_stimulus(0, 0, 1);
    check_flags("ce_pop", 1'b1, 1'b0);
    apply_stimulus(0, 0, 1);
    check_flags("pop_empty", 1'b1, 1'b0);
    check_occ("pop_empty", 3'd0);
    apply_stimulus(1, 0, 0);
    check_flags("after_empty_pop", 1'b1, 1'b1);
    check_output("after_empty_pop_dout", {7'd0, if_dout}, 8'h0);
    apply_stimulus(1, 1, 0);
    check_output("two_held_dout", {7'd0, if_dout}, 8'h0);
    check_occ("two_held", 3'd2);

    // Asynchronous reset mid-cycle with two tokens held
    if_write = 0; if_read = 0;
    #2;
    reset = 1'b1;
    #1;
    check_flags("async_reset", 1'b1, 1'b0);
    check_occ("async_reset", 3'd0);
    #1;
    reset = 1'b0;
    apply_stimulus(1, 1, 0);
    check_flags("post_reset", 1'b1, 1'b1);
    check_output("post_reset_dout", {7'd0, if_dout}, 8'h1);
    check_occ("post_reset", 3'd1);
    apply_stimulus(1, 0, 0);
    apply_stimulus(1, 0, 0);
    check_flags("post_reset_full", 1'b0, 1'b1);
    check_output("post_reset_full_dout", {7'd0, if_dout}, 8'h1);
    apply_stimulus(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
